// File: rtl/zrb_sd_cmd_framer.sv
// zrb_sd_cmd_framer: builds the 6-byte SD SPI command frame, drains its echo, then polls for R1.
// Build option ZRB_SD_CMD_CRC_EN: compute the frame CRC7 serially; otherwise B5 is a per-command constant.
module zrb_sd_cmd_framer #(
  parameter logic [7:0] NCR_MAX   = 8'd8,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_full,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        rx_empty
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_SEND    = 3'd2,
    S_POLL_WR = 3'd3,
    S_POLL_RD = 3'd4
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [5:0]  index_r;
  logic [31:0] arg_r;
  logic [2:0]  tx_cnt_r, tx_cnt_nxt_s;
  logic [2:0]  rx_cnt_r, rx_cnt_nxt_s;
  logic [7:0]  poll_cnt_r, poll_cnt_nxt_s;
  logic        busy_r, done_r, timeout_r;
  logic [7:0]  resp_r;
  logic        accept_s, resp_ok_s, resp_to_s;
  logic [7:0]  b5_s;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [5:0] index,
                                            input logic [31:0] arg, input logic [7:0] b5);
    case (idx)
      3'd0:    frame_byte = {2'b01, index};
      3'd1:    frame_byte = arg[31:24];
      3'd2:    frame_byte = arg[23:16];
      3'd3:    frame_byte = arg[15:8];
      3'd4:    frame_byte = arg[7:0];
      default: frame_byte = b5;
    endcase
  endfunction

`ifdef ZRB_SD_CMD_CRC_EN
  logic [6:0]  crc_r;
  logic [5:0]  bit_cnt_r;
  logic [39:0] crc_msg_s;
  logic        calc_last_s;

  // One step of CRC7 (x^7 + x^3 + 1), message bit shifted in MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign crc_msg_s   = {2'b01, index_r, arg_r};
  assign calc_last_s = (bit_cnt_r == 6'd39);
  assign b5_s        = {crc_r, 1'b1};

  // Serial CRC over B0..B4, one bit per CALC cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_r     <= 7'd0;
      bit_cnt_r <= 6'd0;
    end else if (accept_s) begin
      crc_r     <= 7'd0;
      bit_cnt_r <= 6'd0;
    end else if (state_r == S_CALC) begin
      crc_r     <= crc7_step(crc_r, crc_msg_s[6'd39 - bit_cnt_r]);
      bit_cnt_r <= bit_cnt_r + 6'd1;
    end
  end
`else
  // Fixed trailer: valid CRC for CMD0 and CMD8(0x1AA), dummy CRC elsewhere.
  always_comb begin
    case (index_r)
      6'd0:    b5_s = 8'h95;
      6'd8:    b5_s = 8'h87;
      default: b5_s = 8'h01;
    endcase
  end
`endif

  // Next-state decode; FIFO strobes are qualified by same-cycle full/empty flags.
  always_comb begin
    state_nxt_s    = state_r;
    tx_cnt_nxt_s   = tx_cnt_r;
    rx_cnt_nxt_s   = rx_cnt_r;
    poll_cnt_nxt_s = poll_cnt_r;
    tx_wr          = 1'b0;
    tx_data        = 8'h00;
    rx_rd          = 1'b0;
    accept_s       = 1'b0;
    resp_ok_s      = 1'b0;
    resp_to_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_start) begin
          accept_s       = 1'b1;
          tx_cnt_nxt_s   = 3'd0;
          rx_cnt_nxt_s   = 3'd0;
          poll_cnt_nxt_s = 8'd0;
`ifdef ZRB_SD_CMD_CRC_EN
          state_nxt_s    = S_CALC;
`else
          state_nxt_s    = S_SEND;
`endif
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CALC: begin
`ifdef ZRB_SD_CMD_CRC_EN
        if (calc_last_s) begin
          state_nxt_s = S_SEND;
        end else begin
          state_nxt_s = S_CALC;
        end
`else
        state_nxt_s = S_SEND;
`endif
      end
      S_SEND: begin
        if (!tx_full && (tx_cnt_r < 3'd6)) begin
          tx_wr        = 1'b1;
          tx_data      = frame_byte(tx_cnt_r, index_r, arg_r, b5_s);
          tx_cnt_nxt_s = tx_cnt_r + 3'd1;
        end else begin
          tx_cnt_nxt_s = tx_cnt_r;
        end
        if (!rx_empty && (rx_cnt_r < 3'd6)) begin
          rx_rd        = 1'b1;
          rx_cnt_nxt_s = rx_cnt_r + 3'd1;
        end else begin
          rx_cnt_nxt_s = rx_cnt_r;
        end
        if ((tx_cnt_nxt_s == 3'd6) && (rx_cnt_nxt_s == 3'd6)) begin
          state_nxt_s = S_POLL_WR;
        end else begin
          state_nxt_s = S_SEND;
        end
      end
      S_POLL_WR: begin
        if (!tx_full) begin
          tx_wr          = 1'b1;
          tx_data        = FILL_BYTE;
          poll_cnt_nxt_s = poll_cnt_r + 8'd1;
          state_nxt_s    = S_POLL_RD;
        end else begin
          state_nxt_s = S_POLL_WR;
        end
      end
      S_POLL_RD: begin
        if (!rx_empty) begin
          rx_rd = 1'b1;
          if (!rx_data[7]) begin
            resp_ok_s   = 1'b1;
            state_nxt_s = S_IDLE;
          end else if (poll_cnt_r == NCR_MAX) begin
            resp_to_s   = 1'b1;
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = S_POLL_WR;
          end
        end else begin
          state_nxt_s = S_POLL_RD;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, counters, captured command and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      index_r    <= 6'd0;
      arg_r      <= 32'd0;
      tx_cnt_r   <= 3'd0;
      rx_cnt_r   <= 3'd0;
      poll_cnt_r <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
      resp_r     <= 8'hFF;
    end else begin
      state_r    <= state_nxt_s;
      tx_cnt_r   <= tx_cnt_nxt_s;
      rx_cnt_r   <= rx_cnt_nxt_s;
      poll_cnt_r <= poll_cnt_nxt_s;
      done_r     <= resp_ok_s | resp_to_s;
      if (accept_s) begin
        index_r   <= cmd_index;
        arg_r     <= cmd_arg;
        busy_r    <= 1'b1;
        timeout_r <= 1'b0;
      end else if (resp_ok_s) begin
        busy_r <= 1'b0;
        resp_r <= rx_data;
      end else if (resp_to_s) begin
        busy_r    <= 1'b0;
        resp_r    <= 8'hFF;
        timeout_r <= 1'b1;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign resp    = resp_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_zrb_sd_cmd_framer.sv
// tb_zrb_sd_cmd_framer: table-driven and randomized checks of the SD command framer against
// a bench-side card/FIFO model; honours ZRB_SD_CMD_CRC_EN for the expected B5 and latency.
module tb_zrb_sd_cmd_framer;

  localparam int NCR = 8;
`ifdef ZRB_SD_CMD_CRC_EN
  localparam int CALC_CYC = 40;
`else
  localparam int CALC_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy, done, timeout, tx_wr, rx_rd;
  logic [7:0]  resp, tx_data;
  logic        tx_full, rx_empty;
  logic [7:0]  rx_data;

  zrb_sd_cmd_framer #(.NCR_MAX(8'd8), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .busy(busy), .done(done), .resp(resp), .timeout(timeout),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .rx_data(rx_data),
    .rx_rd(rx_rd), .rx_empty(rx_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          hit;     // poll number on which the card answers (0 = never)
    logic [7:0]  r1;
    logic [7:0]  b5;
    int          polls;
    logic [7:0]  resp;
    logic        to;
    bit          stress;
    bit          spam;
    int          lat;     // expected done cycle after accept, -1 = unchecked
  } vec_t;

  int total = 0;
  int bad = 0;

  logic [7:0] txlog[$];
  logic [7:0] rxq[$];
  int         poll_hit, full_hold, cyc, done_cnt, done_cyc, viol;
  logic [7:0] r1_val, done_resp;
  logic       done_to, s_busy;
  bit         rx_stall_en, tx_rand_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

`ifdef ZRB_SD_CMD_CRC_EN
  // Remainder of msg(x)*x^7 modulo x^7 + x^3 + 1 by long division.
  function automatic logic [6:0] crc_ref(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v = v ^ (47'h89 << (i - 7));
    end
    return v[6:0];
  endfunction
`endif

  function automatic logic [7:0] ref_b5(input logic [5:0] idx, input logic [31:0] arg);
`ifdef ZRB_SD_CMD_CRC_EN
    return {crc_ref({2'b01, idx, arg}), 1'b1};
`else
    if (idx == 6'd0) return 8'h95;
    if (idx == 6'd8) return 8'h87;
    return 8'h01;
`endif
  endfunction

  // One clock: called right after a falling edge; samples just before the rising edge,
  // then applies FIFO/card effects and drives the next inputs on the following falling edge.
  task automatic cycle();
    logic       w, r;
    logic [7:0] wd;
    int         n;
    #4;
    if (tx_wr && tx_full) viol++;
    if (rx_rd && rx_empty) viol++;
    if (done && busy) viol++;
    w  = tx_wr && !tx_full;
    wd = tx_data;
    r  = rx_rd && !rx_empty;
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_resp = resp;
      done_to   = timeout;
    end
    s_busy = busy;
    @(negedge clk);
    cyc++;
    if (r && rxq.size() > 0) void'(rxq.pop_front());
    if (w) begin
      txlog.push_back(wd);
      n = txlog.size();
      if (n > 6 && (n - 6) == poll_hit) rxq.push_back(r1_val);
      else rxq.push_back(8'hFF);
    end
    if (full_hold > 0) begin
      tx_full = 1'b1;
      full_hold--;
    end else begin
      tx_full = tx_rand_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    rx_empty = (rxq.size() == 0) || (rx_stall_en && $urandom_range(0, 2) == 0);
    rx_data  = (rxq.size() > 0) ? rxq[0] : 8'hFF;
  endtask

  task automatic run_cmd(input string tag, input vec_t v);
    bit         spammed, held;
    logic [7:0] eb;
    txlog.delete();
    rxq.delete();
    rx_empty    = 1'b1;
    poll_hit    = v.hit;
    r1_val      = v.r1;
    viol        = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    full_hold   = 0;
    rx_stall_en = v.stress;
    tx_rand_en  = v.stress;
    spammed     = 1'b0;
    held        = 1'b0;
    cmd_index   = v.idx;
    cmd_arg     = v.arg;
    cmd_start   = 1'b1;
    cyc         = 0;
    cycle();
    cmd_start = 1'b0;
    cycle();
    check({tag, " busy_after_accept"}, s_busy, 1);
    for (int k = 0; k < 800 && done_cnt == 0; k++) begin
      if (v.spam && !spammed && (cyc == 3 || txlog.size() == 2)) begin
        cmd_start = 1'b1;
        spammed   = (txlog.size() == 2);
      end else begin
        cmd_start = 1'b0;
      end
      if (v.stress && !held && txlog.size() == 3) begin
        full_hold = 5;
        held      = 1'b1;
      end
      cycle();
    end
    cmd_start = 1'b0;
    check({tag, " done_seen"}, done_cnt != 0, 1);
    for (int k = 0; k < 8; k++) cycle();
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " resp"}, done_resp, v.resp);
    check({tag, " timeout"}, done_to, v.to);
    check({tag, " resp_held"}, resp, v.resp);
    check({tag, " busy_idle"}, busy, 0);
    check({tag, " tx_count"}, txlog.size(), 6 + v.polls);
    for (int k = 0; k < 6 + v.polls && k < txlog.size(); k++) begin
      if (k == 0) eb = {2'b01, v.idx};
      else if (k < 5) eb = 8'(v.arg >> (8 * (4 - k)));
      else if (k == 5) eb = v.b5;
      else eb = 8'hFF;
      check($sformatf("%s tx_byte%0d", tag, k), txlog[k], eb);
    end
    check({tag, " strobe_protocol"}, viol, 0);
    if (v.lat >= 0) check({tag, " latency"}, done_cyc, v.lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    vec_t rv;
    bit   hit_ok;

    vecs[0] = '{6'd0,  32'h0000_0000, 3, 8'h01, 8'h95,                         3,   8'h01, 1'b0, 1'b0, 1'b0, -1};
    vecs[1] = '{6'd8,  32'h0000_01AA, 1, 8'h01, 8'h87,                         1,   8'h01, 1'b0, 1'b0, 1'b0, CALC_CYC + 10};
    vecs[2] = '{6'd17, 32'h0000_0200, 2, 8'h00, ref_b5(6'd17, 32'h200),        2,   8'h00, 1'b0, 1'b1, 1'b0, -1};
    vecs[3] = '{6'd13, 32'h0000_0000, 0, 8'h00, ref_b5(6'd13, 32'h0),          NCR, 8'hFF, 1'b1, 1'b0, 1'b0, -1};
    vecs[4] = '{6'd55, 32'h0000_0000, NCR, 8'h05, ref_b5(6'd55, 32'h0),        NCR, 8'h05, 1'b0, 1'b0, 1'b0, -1};
    vecs[5] = '{6'd41, 32'h4000_0000, NCR + 1, 8'h00, ref_b5(6'd41, 32'h40000000), NCR, 8'hFF, 1'b1, 1'b1, 1'b1, -1};
    vecs[6] = '{6'd24, 32'h1234_5678, 1, 8'h7F, ref_b5(6'd24, 32'h12345678),   1,   8'h7F, 1'b0, 1'b0, 1'b1, -1};

    reset_n   = 1'b0;
    cmd_start = 1'b0;
    cmd_index = 6'd0;
    cmd_arg   = 32'd0;
    tx_full   = 1'b0;
    rx_empty  = 1'b1;
    rx_data   = 8'hFF;
    full_hold = 0;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst timeout", timeout, 0);
    check("rst tx_wr", tx_wr, 0);
    check("rst rx_rd", rx_rd, 0);
    check("rst resp", resp, 8'hFF);
    check("rst tx_data", tx_data, 8'h00);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of SEND must abort at once and leave the block usable.
    txlog.delete();
    rxq.delete();
    poll_hit    = 1;
    r1_val      = 8'h01;
    rx_stall_en = 1'b0;
    tx_rand_en  = 1'b0;
    done_cnt    = 0;
    cmd_index   = 6'd8;
    cmd_arg     = 32'h1AA;
    cmd_start   = 1'b1;
    cycle();
    cmd_start = 1'b0;
    for (int k = 0; k < 200 && txlog.size() < 3; k++) cycle();
    check("midrst reached_send", txlog.size() >= 3, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst tx_wr", tx_wr, 0);
    check("midrst rx_rd", rx_rd, 0);
    check("midrst resp", resp, 8'hFF);
    check("midrst tx_data", tx_data, 8'h00);
    check("midrst timeout", timeout, 0);
    @(negedge clk);
    txlog.delete();
    repeat (3) cycle();
    check("midrst no_done", done_cnt, 0);
    check("midrst no_writes", txlog.size(), 0);
    rxq.delete();
    rx_empty = 1'b1;
    reset_n  = 1'b1;
    run_cmd("post_reset_cmd0", vecs[0]);

    // Randomized commands against the reference rules.
    for (int i = 0; i < 12; i++) begin
      rv.idx    = 6'($urandom_range(0, 63));
      rv.arg    = $urandom;
      rv.hit    = $urandom_range(1, NCR + 2);
      rv.r1     = 8'($urandom_range(0, 127));
      hit_ok    = (rv.hit <= NCR);
      rv.b5     = ref_b5(rv.idx, rv.arg);
      rv.polls  = hit_ok ? rv.hit : NCR;
      rv.resp   = hit_ok ? rv.r1 : 8'hFF;
      rv.to     = !hit_ok;
      rv.stress = 1'($urandom_range(0, 1));
      rv.spam   = 1'($urandom_range(0, 1));
      rv.lat    = -1;
      run_cmd($sformatf("rand%0d", i), rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
